// File: rtl/issue_scoreboard_pkg.sv
// issue_scoreboard_pkg: shared register-id, latency-class and reservation-slot types
package issue_scoreboard_pkg;
  localparam int REG_W = 5;
  localparam int DEF_NUM_SLOTS = 8;
  localparam int DEF_ALU_LAT = 2;
  localparam int DEF_MEM_LAT = 3;
  localparam int DEF_MUL_LAT = 6;
  typedef logic [REG_W-1:0] regid_t;
  typedef enum logic [1:0] {LAT_ALU, LAT_MEM, LAT_MUL} lat_class_t;
  typedef struct packed {
    logic   valid;
    regid_t dst;
  } slot_t;
  function automatic int lat_of(lat_class_t c, int alu, int mem, int mul);
    return c == LAT_MUL ? mul : c == LAT_MEM ? mem : alu;
  endfunction
endpackage

// File: rtl/issue_scoreboard_if.sv
// issue_scoreboard_if: decoder-to-scoreboard issue handshake
interface issue_scoreboard_if;
  import issue_scoreboard_pkg::*;
  logic       issue_valid;
  regid_t     issue_r1;
  regid_t     issue_r2;
  logic       issue_use_r1;
  logic       issue_use_r2;
  regid_t     issue_dst;
  logic       issue_wr;
  lat_class_t issue_class;
  logic       issue_ready;
  modport master (
    output issue_valid, issue_r1, issue_r2, issue_use_r1, issue_use_r2,
           issue_dst, issue_wr, issue_class,
    input  issue_ready
  );
  modport slave (
    input  issue_valid, issue_r1, issue_r2, issue_use_r1, issue_use_r2,
           issue_dst, issue_wr, issue_class,
    output issue_ready
  );
endinterface

// File: rtl/issue_scoreboard_hazard_match.sv
// issue_scoreboard_hazard_match: hit when a nonzero regid matches any valid slot at index >= START
module issue_scoreboard_hazard_match
  import issue_scoreboard_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int START     = 1
) (
  input  regid_t                 reg_i,
  input  slot_t [NUM_SLOTS-1:0]  slots_i,
  output logic                   hit_o
);
  always_comb begin
    hit_o = 1'b0;
    for (int k = START; k < NUM_SLOTS; k++)
      hit_o = hit_o | (slots_i[k].valid && slots_i[k].dst == reg_i && reg_i != '0);
  end
endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: writeback-slot shift register stalling issue on RAW, WAW and write-port conflicts
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int ALU_LAT   = DEF_ALU_LAT,
  parameter int MEM_LAT   = DEF_MEM_LAT,
  parameter int MUL_LAT   = DEF_MUL_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
  issue_scoreboard_if.slave   iss,
  input  logic                freeze,
  input  logic                flush,
  output logic                wb_valid,
  output regid_t              wb_dst,
  output logic [3:0]          pending
);
  if (!(1 <= ALU_LAT && ALU_LAT <= MEM_LAT && MEM_LAT <= MUL_LAT &&
        MUL_LAT <= NUM_SLOTS && NUM_SLOTS <= 15)) begin : g_bad_params
    $error("issue_scoreboard: illegal latency/slot parameters");
  end
  typedef slot_t [NUM_SLOTS-1:0] slot_vec_t;
  slot_vec_t  slots_q, slots_d;
  logic [3:0] pending_q, pending_d;
  logic       hit_r1, hit_r2, hit_dst;
  logic       port_conf, reserve_req, hazard, accept;
  int         lat;
  issue_scoreboard_hazard_match #(.NUM_SLOTS(NUM_SLOTS), .START(1)) u_r1 (
    .reg_i(iss.issue_r1), .slots_i(slots_q), .hit_o(hit_r1));
  issue_scoreboard_hazard_match #(.NUM_SLOTS(NUM_SLOTS), .START(1)) u_r2 (
    .reg_i(iss.issue_r2), .slots_i(slots_q), .hit_o(hit_r2));
  issue_scoreboard_hazard_match #(.NUM_SLOTS(NUM_SLOTS), .START(1)) u_dst (
    .reg_i(iss.issue_dst), .slots_i(slots_q), .hit_o(hit_dst));
  always_comb begin
    lat = lat_of(iss.issue_class, ALU_LAT, MEM_LAT, MUL_LAT);
    port_conf = 1'b0;
    for (int k = 0; k < NUM_SLOTS; k++)
      if (k == lat) port_conf = slots_q[k].valid;
    reserve_req = iss.issue_wr && iss.issue_dst != '0;
    hazard = (iss.issue_use_r1 && hit_r1) || (iss.issue_use_r2 && hit_r2) ||
             (iss.issue_wr && hit_dst) || (reserve_req && port_conf);
    iss.issue_ready = rst_n && !freeze && !flush && !hazard;
    accept = iss.issue_valid && iss.issue_ready;
  end
  // the slot at lat-1 is always free after the shift because port_conf checked slot[lat]
  always_comb begin
    slots_d = slots_q;
    if (flush) slots_d = '0;
    else if (!freeze) begin
      slots_d = slots_q >> $bits(slot_t);
      for (int k = 0; k < NUM_SLOTS; k++)
        if (accept && reserve_req && k == lat - 1) slots_d[k] = '{valid: 1'b1, dst: iss.issue_dst};
    end
    pending_d = '0;
    for (int k = 0; k < NUM_SLOTS; k++)
      pending_d = pending_d + 4'(slots_d[k].valid);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slots_q   <= '0;
      pending_q <= '0;
    end else begin
      slots_q   <= slots_d;
      pending_q <= pending_d;
    end
  assign wb_valid = slots_q[0].valid;
  assign wb_dst   = slots_q[0].dst;
  assign pending  = pending_q;
endmodule
